// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited issue, a response
// FIFO with empty-bypass, and redirect squashing. Optional IRQ: FETCH_IRQ_EN.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif
`ifndef INST_BNE_EXCEPT
`define INST_BNE_EXCEPT 32'h0000_1063
`endif

module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR    = 32'h8000_0000,
`ifdef FETCH_IRQ_EN
    parameter logic [31:0] XADR_VECTOR     = 32'h8000_0008,
`endif
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
`ifdef FETCH_IRQ_EN
    input  logic        irq,
`endif
    output logic [31:0] pc,
    output logic [31:0] ir
);

    localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [3:0] MAXC = 4'(MAX_OUTSTANDING);

    // Supervisor bit 31 is preserved; the low 31 bits wrap.
    function automatic logic [31:0] inc_pc(input logic [31:0] a);
        return {a[31], a[30:0] + 31'd4};
    endfunction

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        if (p == AW'(MAX_OUTSTANDING - 1)) return '0;
        return p + 1'b1;
    endfunction

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    // Address of the next non-squashed response expected from memory.
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [2:0]    out_q, out_d;
    logic [2:0]    disc_q, disc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [31:0]   fifo_pc_q [MAX_OUTSTANDING];
    logic [31:0]   fifo_pc_d [MAX_OUTSTANDING];
    logic [31:0]   fifo_ir_q [MAX_OUTSTANDING];
    logic [31:0]   fifo_ir_d [MAX_OUTSTANDING];
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   ir_q, ir_d;

    logic          irq_take;
    logic          take_redir;
    logic [31:0]   redir_target;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_take;
    logic          rsp_keep;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic          unused_addr_lsb;

    assign unused_addr_lsb = ^redirect_addr[1:0];

`ifdef FETCH_IRQ_EN
    // Interrupts are only taken in user mode and never against a stall.
    assign irq_take = irq && !fetch_pc_q[31] && !stall && !redirect;
    assign redir_target = redirect ? {redirect_addr[31:2], 2'b00}
                                   : {XADR_VECTOR[31:2], 2'b00};
`else
    assign irq_take = 1'b0;
    assign redir_target = {redirect_addr[31:2], 2'b00};
`endif

    assign take_redir = redirect || irq_take;
    assign credit_ok  = ({1'b0, out_q} + {1'b0, cnt_q}) < MAXC;

    assign imem_req_valid = !rst && !take_redir && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take   = imem_rsp_valid && (out_q != 3'd0);
    assign rsp_keep   = rsp_take && (disc_q == 3'd0);
    assign fifo_empty = (cnt_q == 3'd0);
    assign pop        = !stall && !fifo_empty;
    assign push       = rsp_keep && (stall || !fifo_empty);

    assign pc = pc_q;
    assign ir = ir_q;

    // Next-state: issue, response capture, delivery and redirect squash.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_d      = out_q + {2'b00, req_fire} - {2'b00, rsp_take};
        disc_d     = disc_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        fifo_pc_d  = fifo_pc_q;
        fifo_ir_d  = fifo_ir_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        if (take_redir) begin
            fetch_pc_d = redir_target;
            rsp_pc_d   = redir_target;
            disc_d     = out_q - {2'b00, rsp_take};
            cnt_d      = 3'd0;
            rd_d       = '0;
            wr_d       = '0;
            ir_d       = `INST_NOP;
`ifdef FETCH_IRQ_EN
            if (irq_take) begin
                ir_d = `INST_BNE_EXCEPT;
                pc_d = fifo_empty ? inc_pc(rsp_pc_q) : fifo_pc_q[rd_q];
            end
`endif
        end else begin
            if (req_fire) fetch_pc_d = inc_pc(fetch_pc_q);
            if (rsp_take && (disc_q != 3'd0)) disc_d = disc_q - 3'd1;
            if (rsp_keep) rsp_pc_d = inc_pc(rsp_pc_q);
            if (!stall) begin
                if (!fifo_empty) begin
                    pc_d = fifo_pc_q[rd_q];
                    ir_d = fifo_ir_q[rd_q];
                    rd_d = nxt(rd_q);
                end else if (rsp_keep) begin
                    pc_d = inc_pc(rsp_pc_q);
                    ir_d = imem_rsp_data;
                end else begin
                    ir_d = `INST_NOP;
                end
            end
            if (push) begin
                fifo_pc_d[wr_q] = inc_pc(rsp_pc_q);
                fifo_ir_d[wr_q] = imem_rsp_data;
                wr_d            = nxt(wr_q);
            end
            cnt_d = cnt_q + {2'b00, push} - {2'b00, pop};
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_VECTOR;
            rsp_pc_q   <= RESET_VECTOR;
            out_q      <= 3'd0;
            disc_q     <= 3'd0;
            cnt_q      <= 3'd0;
            rd_q       <= '0;
            wr_q       <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_pc_q[i] <= 32'd0;
                fifo_ir_q[i] <= 32'd0;
            end
            pc_q       <= RESET_VECTOR;
            ir_q       <= `INST_NOP;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_q      <= out_d;
            disc_q     <= disc_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            fifo_pc_q  <= fifo_pc_d;
            fifo_ir_q  <= fifo_ir_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a 1-cycle memory model
// that returns the request address as data and can hold responses back.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module tb_fetch_unit;

    localparam logic [31:0] RV  = 32'h8000_0000;
    localparam logic [31:0] NOP = `INST_NOP;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic [31:0] pc;
    logic [31:0] ir;
`ifdef FETCH_IRQ_EN
    logic        irq = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    logic        hold;
    logic [31:0] q_addr[$];
    logic [31:0] acc_log[$];
    int          fire_cnt = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req_valid),
        .imem_req_ready (req_ready),
        .imem_req_addr  (req_addr),
        .imem_rsp_valid (rsp_valid),
        .imem_rsp_data  (rsp_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
`ifdef FETCH_IRQ_EN
        .irq            (irq),
`endif
        .pc             (pc),
        .ir             (ir)
    );

    always #5 clk = ~clk;

    // Memory: accept at posedge, answer in the following cycle unless held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_addr.delete();
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
        end else begin
            if (req_valid && req_ready) begin
                q_addr.push_back(req_addr);
                acc_log.push_back(req_addr);
                fire_cnt++;
            end
            if (!hold && q_addr.size() > 0) begin
                rsp_valid <= 1'b1;
                rsp_data  <= q_addr.pop_front();
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; req_ready = 1'b1;
        stall = 1'b0; redirect = 1'b0; redirect_addr = 32'd0;
        repeat (2) @(negedge clk);
        total++;
        if (ir !== NOP) begin bad++;
            $display("FAIL reset_ir got=%h exp=%h", ir, NOP); end
        total++;
        if (pc !== RV) begin bad++;
            $display("FAIL reset_pc got=%h exp=%h", pc, RV); end
        total++;
        if (req_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid got=%b exp=0", req_valid); end
        rst = 1'b0;
        #1;
        total++;
        if (req_valid !== 1'b1 || req_addr !== RV) begin bad++;
            $display("FAIL first_req got=%b/%h exp=1/%h",
                     req_valid, req_addr, RV); end
    endtask

    task automatic test_stream();
        logic [31:0] e;
        @(negedge clk);
        total++;
        if (ir !== NOP) begin bad++;
            $display("FAIL startup_ir got=%h exp=%h", ir, NOP); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            e = RV + 32'(4 * i);
            total++;
            if (ir !== e || pc !== e + 32'd4) begin bad++;
                $display("FAIL stream_%0d got=%h/%h exp=%h/%h",
                         i, ir, pc, e, e + 32'd4); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] x;
        logic [31:0] p;
        int f0;
        x = ir; p = pc; f0 = fire_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (ir !== x || pc !== p) begin bad++;
                $display("FAIL stall_hold_%0d got=%h/%h exp=%h/%h",
                         i, ir, pc, x, p); end
        end
        stall = 1'b0;
        total++;
        if (fire_cnt - f0 != 1) begin bad++;
            $display("FAIL stall_credit got=%0d exp=1", fire_cnt - f0); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (ir !== x + 32'(4 * i) || pc !== x + 32'(4 * i + 4)) begin
                bad++;
                $display("FAIL stall_resume_%0d got=%h/%h exp=%h/%h", i,
                         ir, pc, x + 32'(4 * i), x + 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_redirect();
        int mark;
        bit found;
        hold = 1'b1;
        repeat (2) @(negedge clk);
        redirect = 1'b1; redirect_addr = 32'h0000_0103;
        #1;
        total++;
        if (req_valid !== 1'b0) begin bad++;
            $display("FAIL redir_no_issue got=%b exp=0", req_valid); end
        @(negedge clk);
        redirect = 1'b0; hold = 1'b0;
        mark = acc_log.size();
        total++;
        if (ir !== NOP) begin bad++;
            $display("FAIL redir_nop got=%h exp=%h", ir, NOP); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ir !== NOP) begin found = 1'b1; break; end
        end
        total++;
        if (!found || ir !== 32'h100 || pc !== 32'h104) begin bad++;
            $display("FAIL redir_first got=%h/%h found=%0d exp=100/104",
                     ir, pc, found); end
        total++;
        if (acc_log.size() <= mark || acc_log[mark] !== 32'h100) begin
            bad++;
            $display("FAIL redir_addr got=%h exp=00000100",
                     (acc_log.size() > mark) ? acc_log[mark] : 32'hx); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_redirect_stall();
        logic [31:0] p;
        bit found;
        p = pc;
        stall = 1'b1; redirect = 1'b1; redirect_addr = 32'h0000_0200;
        @(negedge clk);
        stall = 1'b0; redirect = 1'b0;
        total++;
        if (ir !== NOP || pc !== p) begin bad++;
            $display("FAIL rs_nop got=%h/%h exp=%h/%h", ir, pc, NOP, p); end
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ir !== NOP) begin found = 1'b1; break; end
        end
        total++;
        if (!found || ir !== 32'h200 || pc !== 32'h204) begin bad++;
            $display("FAIL rs_first got=%h/%h found=%0d exp=200/204",
                     ir, pc, found); end
        @(negedge clk);
        total++;
        if (ir !== 32'h204 || pc !== 32'h208) begin bad++;
            $display("FAIL rs_next got=%h/%h exp=204/208", ir, pc); end
    endtask

    task automatic test_wrap();
        int mark;
        bit found;
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
        mark = acc_log.size();
        @(negedge clk);
        redirect = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ir !== NOP) begin found = 1'b1; break; end
        end
        total++;
        if (!found || ir !== 32'hFFFF_FFFC || pc !== 32'h8000_0000) begin
            bad++;
            $display("FAIL wrap_first got=%h/%h exp=fffffffc/80000000",
                     ir, pc); end
        @(negedge clk);
        total++;
        if (ir !== 32'h8000_0000 || pc !== 32'h8000_0004) begin bad++;
            $display("FAIL wrap_next got=%h/%h exp=80000000/80000004",
                     ir, pc); end
        total++;
        if (acc_log.size() < mark + 2 || acc_log[mark] !== 32'hFFFF_FFFC
            || acc_log[mark + 1] !== 32'h8000_0000) begin
            bad++;
            $display("FAIL wrap_addr got=%h,%h exp=fffffffc,80000000",
                     (acc_log.size() > mark) ? acc_log[mark] : 32'hx,
                     (acc_log.size() > mark + 1) ? acc_log[mark + 1] : 32'hx);
        end
    endtask

    task automatic test_async_reset();
        int mark;
        bit found;
        hold = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (req_valid !== 1'b0 || ir !== NOP || pc !== RV) begin bad++;
            $display("FAIL async_rst got=%b/%h/%h exp=0/%h/%h",
                     req_valid, ir, pc, NOP, RV); end
        @(negedge clk);
        rst = 1'b0; hold = 1'b0;
        mark = acc_log.size();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ir !== NOP) begin found = 1'b1; break; end
        end
        total++;
        if (!found || ir !== RV || pc !== RV + 32'd4) begin bad++;
            $display("FAIL refetch got=%h/%h found=%0d exp=%h/%h",
                     ir, pc, found, RV, RV + 32'd4); end
        total++;
        if (acc_log.size() <= mark || acc_log[mark] !== RV) begin bad++;
            $display("FAIL refetch_addr got=%h exp=%h",
                     (acc_log.size() > mark) ? acc_log[mark] : 32'hx, RV); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Issues in-order read requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Buffers returned instructions and presents {pc, ir} to the decode stage.
- Decode latches ir every cycle and pc only when not stalled, so fetch holds both stable while stall is high.
- Decode redirects fetch on a taken JMP/BEQ/BNE; wrong-path data already in flight is discarded.

Parameters:
- RESET_VECTOR, 32'h8000_0000, first fetch address after reset.
- MAX_OUTSTANDING, 2, maximum requests in flight plus instructions buffered (credit limit, 1..4).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- imem_req_valid  output  1  request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  word-aligned fetch address
- imem_rsp_valid  input  1  response valid, in request order, latency >= 1 cycle
- imem_rsp_data  input  32  instruction word
- stall  input  1  decode stall; hold pc/ir
- redirect  input  1  taken jump/branch from decode
- redirect_addr  input  32  target address; bits [1:0] ignored
- pc  output  32  fetch address + 4 of the instruction on ir
- ir  output  32  instruction to decode

Behaviour:
- Reset (async, any time, including with requests in flight):
  - fetch_pc = RESET_VECTOR; pc = RESET_VECTOR; ir = `INST_NOP.
  - imem_req_valid = 0; buffer empty; outstanding = 0; discard = 0.
  - Responses arriving after reset release and belonging to pre-reset requests are not tracked. Memory must be reset together with fetch.
- Address increment: next = {fetch_pc[31], fetch_pc[30:0] + 4}. The supervisor bit never changes through increment; bits [30:0] wrap at 2^31.
- Issue:
  - imem_req_valid = !rst && !redirect && (outstanding + buf_count) < MAX_OUTSTANDING.
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc advances, outstanding++.
  - Once asserted, valid and addr hold until accepted, unless a redirect occurs.
- Response:
  - imem_rsp_valid with discard > 0: drop the word, discard--, outstanding--.
  - Otherwise push {addr+4, data} into the FIFO (depth MAX_OUTSTANDING), outstanding--.
  - Overflow is impossible by credit. A response with outstanding = 0 is a protocol error and is ignored.
- Delivery (registered outputs, updated at posedge):
  - stall = 1, no redirect: pc and ir hold.
  - stall = 0, FIFO non-empty: pop the head into pc/ir. Bypass: a response arriving into an empty FIFO is delivered the next cycle, giving a 1-cycle rsp-to-ir latency.
  - stall = 0, FIFO empty: ir = `INST_NOP, pc holds.
- Redirect (takes priority over stall and issue):
  - fetch_pc = {redirect_addr[31:2], 2'b00}; FIFO flushed.
  - discard = outstanding minus any response consumed that cycle.
  - ir = `INST_NOP next cycle; pc holds.
  - No request is issued in the redirect cycle. Issue resumes the following cycle from the new target.
- A second redirect while discard > 0 adds new wrong-path requests to discard; discard never underflows.
- Steady-state throughput is 1 instruction/cycle when memory latency is 1 and ready = 1.

Optional Feature:
- Macro FETCH_IRQ_EN adds input irq (1 bit) and parameter XADR_VECTOR (default 32'h8000_0008).
- With the macro: when irq = 1, fetch_pc[31] = 0, stall = 0 and no redirect:
  - Behave as a redirect to XADR_VECTOR.
  - Deliver `INST_BNE_EXCEPT on ir instead of NOP, with pc = address of the squashed instruction + 4, so decode saves the return address.
  - irq is ignored while fetch_pc[31] = 1 (supervisor mode).
- Without the macro: no irq port, no XADR_VECTOR, no interrupt logic.

Test Plan:
- Reset release, ready = 1, 1-cycle memory returning addr-as-data -> requests 0x80000000, 0x80000004, ...; ir sequence 0x80000000, 0x80000004, ... with pc = ir + 4, one per cycle after a 2-cycle startup.
- stall held 3 cycles mid-stream -> pc/ir unchanged for 3 cycles; no request issued beyond the credit limit of 2; no instruction lost or duplicated after release.
- redirect to 0x00000103 with 2 requests outstanding -> both responses dropped; next request address 0x00000100; ir = NOP until the 0x100 word arrives.
- redirect asserted together with stall -> redirect wins; ir = NOP next cycle; fetch resumes at the target.
- fetch_pc = 0x FFFFFFFC (supervisor bit set) -> next address 0x80000000, bit 31 preserved.
- Async rst asserted with 2 requests in flight -> outputs at reset values immediately; refetch from RESET_VECTOR. With FETCH_IRQ_EN, irq in user mode at pc 0x00000040 -> ir = `INST_BNE_EXCEPT, next request 0x80000008.
